// File: rtl/bus_clk_pkg.sv
// bus_clk_pkg: shared state type and default parameters for the bus-clock front end
package bus_clk_pkg;
  typedef enum logic [1:0] {NO_CLK, FIRST_EDGE, RUNNING} bus_clk_state_t;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN = 3;
  localparam int TIMEOUT = 255;
endpackage

// File: rtl/bus_clk_filter.sv
// bus_clk_filter: synchronizes the raw slot clock, deglitches it and emits edge strobes
module bus_clk_filter #(
  parameter int SYNC_STAGES = bus_clk_pkg::SYNC_STAGES,
  parameter int FILTER_LEN = bus_clk_pkg::FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [FILTER_LEN-1:0] win, win_next;
  logic level_next;
  // the level register looks at the window including the sample arriving this edge
  assign win_next = (win << 1) | FILTER_LEN'(sync[SYNC_STAGES-1]);
  assign level_next = &win_next ? 1'b1 : ~|win_next ? 1'b0 : level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      win <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      win <= win_next;
      level <= level_next;
      rise <= level_next & ~level;
      fall <= ~level_next & level;
    end
endmodule

// File: rtl/bus_clk_sync.sv
// bus_clk_sync: bus-clock front end with period measurement and clock-loss detection
module bus_clk_sync #(
  parameter int SYNC_STAGES = bus_clk_pkg::SYNC_STAGES,
  parameter int FILTER_LEN = bus_clk_pkg::FILTER_LEN,
  parameter int TIMEOUT = bus_clk_pkg::TIMEOUT,
  localparam int PERIOD_W = $clog2(TIMEOUT + 1)
) (
  input  logic                RESET_n,
  input  logic                CLK,
  input  logic                BUS_CLK_IN,
  output logic                CLK_3_58M,
  output logic                CLK_3_58M_EN,
  output logic                CLK_3_58M_FALL,
  output logic [PERIOD_W-1:0] PERIOD,
  output logic                PERIOD_VALID,
  output logic                CLK_ALIVE
);
  import bus_clk_pkg::*;
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_TMO = PERIOD_W'(TIMEOUT);
  bus_clk_state_t state, state_next;
  logic [PERIOD_W-1:0] cnt;
  logic timeout;
  bus_clk_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter (
    .clk(CLK),
    .rst_n(RESET_n),
    .raw(BUS_CLK_IN),
    .level(CLK_3_58M),
    .rise(CLK_3_58M_EN),
    .fall(CLK_3_58M_FALL)
  );
  // a rise in the timeout cycle keeps the clock alive
  assign timeout = !CLK_3_58M_EN && cnt == CNT_TMO;
  always_comb
    state_next = CLK_3_58M_EN ? (state == NO_CLK ? FIRST_EDGE : RUNNING) : timeout ? NO_CLK : state;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) state <= NO_CLK;
    else state <= state_next;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      cnt <= '0;
      PERIOD <= '0;
    end else begin
      cnt <= CLK_3_58M_EN ? PERIOD_W'(1) : cnt == CNT_MAX ? cnt : cnt + 1'b1;
      if (CLK_3_58M_EN && state != NO_CLK) PERIOD <= cnt;
    end
  assign CLK_ALIVE = state == RUNNING;
  assign PERIOD_VALID = CLK_ALIVE;
endmodule

// File: tb/tb_bus_clk_sync.sv
// tb_bus_clk_sync: random and directed stimulus against a behavioural model of bus_clk_sync
module tb_bus_clk_sync;
  localparam int S = 2, F = 3, TMO = 255, PMAX = 255;
  logic RESET_n = 1'b0, CLK = 1'b0, BUS_CLK_IN = 1'b0;
  logic CLK_3_58M, CLK_3_58M_EN, CLK_3_58M_FALL, PERIOD_VALID, CLK_ALIVE;
  logic [7:0] PERIOD;
  int errors = 0, checks = 0;
  bit hist[$];
  bit m_level, m_en, m_fall, m_alive, prev;
  int m_period, run, last, n, en_cnt, fall_cnt;
  bus_clk_sync dut (
    .RESET_n(RESET_n),
    .CLK(CLK),
    .BUS_CLK_IN(BUS_CLK_IN),
    .CLK_3_58M(CLK_3_58M),
    .CLK_3_58M_EN(CLK_3_58M_EN),
    .CLK_3_58M_FALL(CLK_3_58M_FALL),
    .PERIOD(PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .CLK_ALIVE(CLK_ALIVE)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // true when the F inputs seen S edges ago are all equal to v
  function automatic bit window_is(input bit v);
    int l = hist.size();
    bit s;
    for (int j = l - S - F; j <= l - 1 - S; j++) begin
      s = 1'b0;
      if (j >= 0) s = hist[j];
      if (s != v) return 1'b0;
    end
    return 1'b1;
  endfunction
  // model: m_en marks the cycle of a filtered rise; last holds that cycle's index
  always @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      hist.delete();
      m_level = 0; m_en = 0; m_fall = 0; m_alive = 0;
      m_period = 0; run = 0; last = 0;
    end else begin
      n = hist.size();
      if (m_en) begin
        if (run > 0) m_period = (n - 1 - last) > PMAX ? PMAX : n - 1 - last;
        run = run < 2 ? run + 1 : 2;
        last = n - 1;
      end else if (run > 0 && n - 1 - last == TMO) run = 0;
      m_alive = run == 2;
      hist.push_back(BUS_CLK_IN);
      prev = m_level;
      if (window_is(1'b1)) m_level = 1'b1;
      else if (window_is(1'b0)) m_level = 1'b0;
      m_en = m_level & ~prev;
      m_fall = ~m_level & prev;
    end
  end
  always @(negedge CLK) if (RESET_n) begin
    chk("level", CLK_3_58M, m_level);
    chk("en", CLK_3_58M_EN, m_en);
    chk("fall", CLK_3_58M_FALL, m_fall);
    chk("period", PERIOD, m_period);
    chk("valid", PERIOD_VALID, m_alive);
    chk("alive", CLK_ALIVE, m_alive);
    en_cnt += int'(CLK_3_58M_EN);
    fall_cnt += int'(CLK_3_58M_FALL);
  end
  task automatic hold(input bit v, input int cycles);
    @(negedge CLK) BUS_CLK_IN = v;
    repeat (cycles - 1) @(negedge CLK);
  endtask
  task automatic clocks(input int hi, input int lo, input int cnt);
    repeat (cnt) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask
  task automatic zero_outs(input string tag);
    chk({tag, "_level"}, CLK_3_58M, 0);
    chk({tag, "_en"}, CLK_3_58M_EN, 0);
    chk({tag, "_fall"}, CLK_3_58M_FALL, 0);
    chk({tag, "_period"}, PERIOD, 0);
    chk({tag, "_valid"}, PERIOD_VALID, 0);
    chk({tag, "_alive"}, CLK_ALIVE, 0);
  endtask
  initial begin
    int first, nw, w, e0, f0, hi, lo;
    hold(1'b0, 4);
    zero_outs("rst");
    @(negedge CLK) RESET_n = 1'b1;
    hold(1'b0, 20);
    clocks(15, 15, 8);
    chk("steady_period", PERIOD, 30);
    chk("steady_valid", PERIOD_VALID, 1);
    chk("steady_alive", CLK_ALIVE, 1);
    @(negedge CLK) BUS_CLK_IN = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (CLK_3_58M_EN && first == 0) first = i;
    end
    chk("rise_latency", first, 5);
    hold(1'b1, 5);
    hold(1'b0, 15);
    clocks(8, 7, 6);
    chk("turbo_period", PERIOD, 15);
    chk("turbo_alive", CLK_ALIVE, 1);
    hold(1'b0, 20);
    e0 = en_cnt; f0 = fall_cnt;
    hold(1'b1, 1); hold(1'b0, 20);
    hold(1'b1, 2); hold(1'b0, 20);
    chk("glitch_en", en_cnt - e0, 0);
    chk("glitch_fall", fall_cnt - f0, 0);
    chk("glitch_level", CLK_3_58M, 0);
    hold(1'b1, 3); hold(1'b0, 20);
    chk("pulse3_en", en_cnt - e0, 1);
    chk("pulse3_fall", fall_cnt - f0, 1);
    clocks(15, 15, 4);
    @(negedge CLK) BUS_CLK_IN = 1'b1;
    nw = 0;
    while (!CLK_3_58M_EN && nw < 10) begin @(negedge CLK); nw++; end
    chk("stop_strobe", nw, 5);
    w = 0;
    while (CLK_ALIVE && w < 400) begin @(negedge CLK); w++; end
    chk("timeout_cycles", w, 256);
    chk("stop_valid", PERIOD_VALID, 0);
    chk("stop_period", PERIOD, 30);
    hold(1'b1, 20);
    hold(1'b0, 15); hold(1'b1, 15);
    chk("restart1_alive", CLK_ALIVE, 0);
    chk("restart1_valid", PERIOD_VALID, 0);
    chk("restart1_period", PERIOD, 30);
    hold(1'b0, 15); hold(1'b1, 15);
    chk("restart2_alive", CLK_ALIVE, 1);
    chk("restart2_period", PERIOD, 30);
    hold(1'b0, 15); hold(1'b1, 15);
    hold(1'b0, 240); hold(1'b1, 15);
    chk("simul_alive", CLK_ALIVE, 1);
    chk("simul_period", PERIOD, 255);
    hold(1'b0, 15);
    repeat (120) begin
      hi = int'($urandom_range(1, 20));
      lo = ($urandom_range(0, 15) == 0) ? int'($urandom_range(240, 280)) : int'($urandom_range(1, 24));
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
    clocks(15, 15, 3);
    hold(1'b1, 8);
    #2 RESET_n = 1'b0;
    #1 zero_outs("midrst");
    hold(1'b1, 3);
    @(negedge CLK) RESET_n = 1'b1;
    e0 = en_cnt;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (CLK_3_58M_EN && first == 0) first = i;
    end
    chk("rel_latency", first, 5);
    chk("rel_en_count", en_cnt - e0, 1);
    chk("rel_level", CLK_3_58M, 1);
    hold(1'b0, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_clk_sync.md
# bus_clk_sync

Front end of the MSX bus-clock path: brings the asynchronous cartridge-slot clock pin into the `CLK` domain, deglitches it, and produces the level/edge-strobe pair (`CLK_3_58M`, `CLK_3_58M_EN`) consumed by the bus-speed detector.
- Also measures the bus-clock period in `CLK` cycles.
- Flags loss of the bus clock so downstream logic can ignore stale speed and period information.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flip-flop count, ≥2.
- `FILTER_LEN`, 3: consecutive equal samples required to change the filtered level, ≥1.
- `TIMEOUT`, 255: `CLK` cycles without a rising edge before the clock is declared lost, ≥2.
- Derived localparam `PERIOD_W = $clog2(TIMEOUT+1)`.

Ports:
- `RESET_n` in 1: asynchronous, active-low reset.
- `CLK` in 1: system clock, 108 MHz nominal; the only clock.
- `BUS_CLK_IN` in 1: raw slot clock pin, asynchronous to `CLK`.
- `CLK_3_58M` out 1: synchronized, filtered bus-clock level.
- `CLK_3_58M_EN` out 1: one-cycle strobe on each filtered rising edge.
- `CLK_3_58M_FALL` out 1: one-cycle strobe on each filtered falling edge.
- `PERIOD` out `PERIOD_W`: last measured rise-to-rise interval, in `CLK` cycles.
- `PERIOD_VALID` out 1: `PERIOD` holds a measurement from the current clock run.
- `CLK_ALIVE` out 1: bus clock is present and running.

## Operation
- **Synchronizer:** a chain of `SYNC_STAGES` flip-flops, all reset to 0. Nothing else samples `BUS_CLK_IN`.
- **Filter:**
  - Shift register of the last `FILTER_LEN` synchronized samples, reset to all 0.
  - Filtered level goes to 1 when all samples are 1, goes to 0 when all samples are 0, otherwise holds.
  - Pulses shorter than `FILTER_LEN` cycles are dropped.
- **Edge strobes:**
  - `CLK_3_58M_EN` is asserted in exactly the first cycle in which `CLK_3_58M` reads 1 after reading 0.
  - `CLK_3_58M_FALL` is the mirror for 1→0.
  - The two strobes are never both high.
- **Interval counter:**
  - Counts cycles since the last rise and saturates at `2^PERIOD_W-1`.
  - On a rise it restarts so that the count equals the rise-to-rise distance at the next rise.
- **State machine** (states `NO_CLK`, `FIRST_EDGE`, `RUNNING`; reset state `NO_CLK`):
  - `NO_CLK` →rise→ `FIRST_EDGE`. Counter restarts; `PERIOD` is not updated.
  - `FIRST_EDGE` →rise→ `RUNNING`. `PERIOD` is loaded, `PERIOD_VALID`=1, `CLK_ALIVE`=1.
  - `RUNNING` →rise→ `RUNNING`. `PERIOD` is reloaded.
  - Any state → `NO_CLK` when the counter reaches `TIMEOUT` with no rise in that cycle. `PERIOD_VALID`=0 and `CLK_ALIVE`=0; `PERIOD` holds its old value.
- **Rise and timeout in the same cycle:** the rise wins and the timeout is ignored.
- **Reset values:** all outputs 0, state `NO_CLK`.
- **Reset asserted mid-operation:** clears everything immediately. After release, a steady-high input yields one `CLK_3_58M_EN` at the normal latency.

## Timing
- Let edge k be the first `CLK` edge that samples `BUS_CLK_IN`=1 (setup met).
  - `CLK_3_58M` and `CLK_3_58M_EN` both become 1 after edge k+`SYNC_STAGES`+`FILTER_LEN`−1.
  - With the defaults that is 5 cycles of latency.
  - Falling edges have identical latency.
- **`PERIOD` / `PERIOD_VALID` / `CLK_ALIVE`:**
  - They update on the edge that ends the `CLK_3_58M_EN` cycle, i.e. they are visible one cycle after the strobe.
  - Example: strobes in cycles 0 and 30 give `PERIOD`=30 from cycle 31.
- **Timeout:**
  - `CLK_ALIVE` falls one cycle after the counter equals `TIMEOUT`.
  - That is `TIMEOUT`+1 cycles after the last `CLK_3_58M_EN`.
- **Saturation:** `PERIOD` saturates at `2^PERIOD_W-1` and never wraps. This value is reachable only when `TIMEOUT` = `2^PERIOD_W-1` and rise and timeout coincide.

## Structure
- **Shared package `bus_clk_pkg`:**
  - State enum typedef `bus_clk_state_t` {`NO_CLK`, `FIRST_EDGE`, `RUNNING`}.
  - Default constants: `SYNC_STAGES`=2, `FILTER_LEN`=3, `TIMEOUT`=255.
- **Sub-module `bus_clk_filter`:**
  - Contains the synchronizer, the filter and the edge strobes.
  - Outputs: level, rise strobe and fall strobe.
- **Top level:** holds the interval counter, the state machine and the `PERIOD` register.

## Test plan
- **Steady 3.58 MHz** (15/15 `CLK` cycles high/low):
  - `CLK_3_58M_EN` every 30 cycles, 5 cycles after each input rise.
  - `PERIOD`=30 and `PERIOD_VALID`=1 from one cycle after the second strobe.
  - `CLK_ALIVE`=1.
- **Glitches:**
  - 1- and 2-cycle high pulses on a low input give no strobe and `CLK_3_58M`=0.
  - A 3-cycle pulse gives exactly one `CLK_3_58M_EN` and one `CLK_3_58M_FALL`.
- **Turbo clock** (7.16 MHz, 8/7 cycles high/low): `PERIOD` moves from 30 to 15 on the second fast rise, with no invalid gap.
- **Clock stops high:**
  - `CLK_ALIVE` and `PERIOD_VALID` fall 256 cycles after the last strobe, and `PERIOD` keeps 30.
  - On restart, the first rise updates nothing; the second rise restores `CLK_ALIVE`=1.
- **Simultaneous rise and timeout:** an input rise timed so the strobe lands in the cycle the counter equals 255 leaves `CLK_ALIVE`=1 and gives `PERIOD`=255.
- **Reset mid-run:**
  - Assert `RESET_n` during a high phase: all outputs go to 0 immediately.
  - After release with the input held high, `CLK_3_58M_EN` pulses once, 5 cycles after release.
